// File: rtl/cnn_addr_pkg.sv
// cnn_addr_pkg: shared mode encodings, default geometry and sequencer states
package cnn_addr_pkg;
  localparam logic MODE_BLK = 1'b0;
  localparam logic MODE_COL = 1'b1;
  localparam int ROW_W_DEF = 30;
  localparam int BLK_DEPTH_DEF = 480;
  typedef enum logic [1:0] {IDLE, DIV, STREAM, DONE} state_e;
endpackage

// File: rtl/bram_addr_seq_if.sv
// bram_addr_seq_if: valid/ready beat stream carrying one bank/address pair per beat
interface bram_addr_seq_if #(
  parameter int ADDR_W = 15,
  parameter int BANK_W = 6,
  parameter int BADDR_W = 11
);
  logic               out_valid;
  logic               out_ready;
  logic [BANK_W-1:0]  out_bramnum;
  logic [BADDR_W-1:0] out_bramaddr;
  logic [ADDR_W-1:0]  out_dataaddr;
  logic               out_last;
  logic               out_oob;
  modport master (output out_valid, out_bramnum, out_bramaddr, out_dataaddr, out_last, out_oob, input out_ready);
  modport slave (input out_valid, out_bramnum, out_bramaddr, out_dataaddr, out_last, out_oob, output out_ready);
endinterface

// File: rtl/addr_div_iter.sv
// addr_div_iter: restoring divider, one quotient bit per cycle, first bit taken on the start cycle
module addr_div_iter #(
  parameter int W = 15,
  parameter int RW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [RW-1:0] divisor,
  output logic          done,
  output logic [W-1:0]  quo,
  output logic [RW-1:0] rem
);
  localparam int CW = $clog2(W);
  logic [W-1:0]  quo_q, quo_d, src_quo;
  logic [RW-1:0] rem_q, rem_d, dvs_q, dvs_d, src_rem, src_d;
  logic [RW:0]   trial;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d, ge, adv;
  assign done = run_q && cnt_q == '0;
  assign quo = quo_q;
  assign rem = rem_q;
  // one shift-subtract step per cycle, seeded from the operands on start
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_d = start ? divisor : dvs_q;
    trial = {src_rem, src_quo[W-1]};
    ge = trial >= {1'b0, src_d};
    adv = start || (run_q && cnt_q != '0);
    quo_d = adv ? {src_quo[W-2:0], ge} : quo_q;
    rem_d = adv ? (ge ? RW'(trial - {1'b0, src_d}) : RW'(trial)) : rem_q;
    dvs_d = src_d;
    cnt_d = start ? CW'(W - 1) : (adv ? cnt_q - 1'b1 : cnt_q);
    run_d = start || (run_q && !done);
  end
  // divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/bram_addr_seq.sv
// bram_addr_seq: streams banked BRAM (bank, offset) pairs for a run of linear data addresses
module bram_addr_seq
  import cnn_addr_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int BANK_W = 6,
  parameter int BADDR_W = 11,
  parameter int ROW_W = ROW_W_DEF,
  parameter int BLK_DEPTH = BLK_DEPTH_DEF,
  parameter int NUM_BANKS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  bram_addr_seq_if.master   o
);
  localparam int RW = $clog2(ROW_W > BLK_DEPTH ? ROW_W : BLK_DEPTH);
  state_e state_q, state_d;
  logic mode_q, mode_d, last_q, last_d, oob_q, oob_d, hs, wrap;
  logic div_start, div_done;
  logic [ADDR_W-1:0] q_q, q_d, addr_q, addr_d, div_q, bank_f, baddr_f;
  logic [RW-1:0] r_q, r_d, div_r, dmax;
  logic [ADDR_W:0] rem_q, rem_d;
  logic [BANK_W-1:0] num_q, num_d;
  logic [BADDR_W-1:0] baddr_q, baddr_d;
  assign div_start = state_q == IDLE && start && count != '0;
  assign dmax = RW'((mode_q == MODE_COL ? ROW_W : BLK_DEPTH) - 1);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign o.out_valid = state_q == STREAM;
  assign o.out_bramnum = num_q;
  assign o.out_bramaddr = baddr_q;
  assign o.out_dataaddr = addr_q;
  assign o.out_last = last_q;
  assign o.out_oob = oob_q;
  addr_div_iter #(.W(ADDR_W), .RW(RW)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend(start_addr),
    .divisor(RW'(mode == MODE_COL ? ROW_W : BLK_DEPTH)),
    .done(div_done),
    .quo(div_q),
    .rem(div_r)
  );
  // sequencer: capture request, wait for divider, then step bank/offset per accepted beat
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    q_d = q_q;
    r_d = r_q;
    addr_d = addr_q;
    rem_d = rem_q;
    hs = state_q == STREAM && o.out_ready;
    wrap = &addr_q;
    if (state_q == IDLE && start) begin
      mode_d = mode;
      addr_d = start_addr;
      rem_d = count;
      state_d = count == '0 ? DONE : DIV;
    end
    if (state_q == DIV && div_done) begin
      q_d = div_q;
      r_d = div_r;
      state_d = STREAM;
    end
    if (hs) begin
      state_d = last_q ? DONE : STREAM;
      if (!last_q) begin
        addr_d = addr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        q_d = wrap ? '0 : (r_q == dmax ? q_q + 1'b1 : q_q);
        r_d = wrap || r_q == dmax ? '0 : r_q + 1'b1;
      end
    end
    if (state_q == DONE) state_d = IDLE;
    bank_f = mode_d == MODE_COL ? ADDR_W'(r_d) : q_d;
    baddr_f = mode_d == MODE_COL ? q_d : ADDR_W'(r_d);
    num_d = bank_f[BANK_W-1:0];
    baddr_d = baddr_f[BADDR_W-1:0];
    oob_d = bank_f >= ADDR_W'(NUM_BANKS) || (baddr_f >> BADDR_W) != '0;
    last_d = rem_d == (ADDR_W+1)'(1);
  end
  // state and registered beat outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      q_q <= '0;
      r_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      num_q <= '0;
      baddr_q <= '0;
      last_q <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      q_q <= q_d;
      r_q <= r_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      num_q <= num_d;
      baddr_q <= baddr_d;
      last_q <= last_d;
      oob_q <= oob_d;
    end
  end
endmodule

// File: tb/tb_bram_addr_seq.sv
// tb_bram_addr_seq: directed and randomized streams checked against an arithmetic address model
module tb_bram_addr_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [14:0] start_addr = '0;
  logic [15:0] count = '0;
  logic mode = 1'b0;
  logic busy, done;
  int errors = 0;
  int checks = 0;
  bram_addr_seq_if #(.ADDR_W(15), .BANK_W(6), .BADDR_W(11)) bus ();
  logic [33:0] obs;
  assign obs = {bus.out_bramnum, bus.out_bramaddr, bus.out_dataaddr, bus.out_last, bus.out_oob};
  always #5 clk = ~clk;
  bram_addr_seq dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_addr(start_addr),
    .count(count),
    .mode(mode),
    .busy(busy),
    .done(done),
    .o(bus.master)
  );
  function automatic logic [33:0] exp_beat(input bit md, input int addr, input int cnt, input int i);
    int a, d, bank, baddr;
    a = (addr + i) % 32768;
    d = md ? 30 : 480;
    bank = md ? a % d : a / d;
    baddr = md ? a / d : a % d;
    return {6'(bank % 64), 11'(baddr % 2048), 15'(a), i == cnt - 1, bank >= 64 || baddr >= 2048};
  endfunction
  task automatic run(input bit md, input int addr, input int cnt, input int rp, input bit mid_start, input string nm);
    int cyc, beat, first_v, done_c, last_hs, k;
    bit pv, pr, rdy;
    logic [33:0] prev, e;
    @(negedge clk);
    mode = md;
    start_addr = 15'(addr);
    count = 16'(cnt);
    start = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; beat = 0; first_v = -1; done_c = -1; last_hs = 0; k = 0; pv = 0; pr = 0; prev = '0;
    while (done_c < 0 && cyc < 400) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy cyc=%0d got=%b want=1", nm, cyc, busy); end
      if (bus.out_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        if (pv && !pr) begin
          checks++;
          if (obs !== prev) begin errors++; $display("FAIL %s hold cyc=%0d got=%h want=%h", nm, cyc, obs, prev); end
        end
        e = exp_beat(md, addr, cnt, beat);
        checks++;
        if (obs !== e || beat >= cnt) begin errors++; $display("FAIL %s beat%0d got=%h want=%h", nm, beat, obs, e); end
        rdy = rp == 0 ? 1'b1 : (rp == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1)));
        k++;
        bus.out_ready = rdy;
        if (mid_start && beat == 2) begin start = 1'b1; start_addr = 15'd100; count = 16'd3; end
        if (rdy) begin beat++; last_hs = cyc; end
        pv = 1; pr = rdy; prev = obs;
      end else begin
        pv = 0;
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      if (done === 1'b1) done_c = cyc;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (done_c < 0) begin errors++; $display("FAIL %s timeout got=no_done want=done", nm); end
    checks++;
    if (beat != cnt) begin errors++; $display("FAIL %s beats got=%0d want=%0d", nm, beat, cnt); end
    checks++;
    if (first_v != (cnt > 0 ? 16 : -1)) begin errors++; $display("FAIL %s first_valid got=%0d want=%0d", nm, first_v, cnt > 0 ? 16 : -1); end
    checks++;
    if (done_c != (cnt > 0 ? last_hs + 1 : 1)) begin errors++; $display("FAIL %s done_cyc got=%0d want=%0d", nm, done_c, cnt > 0 ? last_hs + 1 : 1); end
    checks++;
    if ({busy, done, bus.out_valid} !== 3'b000) begin errors++; $display("FAIL %s idle_after got=%b want=000", nm, {busy, done, bus.out_valid}); end
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    count = 16'd4;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bus.out_valid, obs} !== 37'd0) begin errors++; $display("FAIL reset got=%h want=0", {busy, done, bus.out_valid, obs}); end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, bus.out_valid} !== 3'b000) begin errors++; $display("FAIL reset_idle got=%b want=000", {busy, done, bus.out_valid}); end
  endtask
  task automatic test_directed();
    run(1'b1, 29, 2, 0, 1'b0, "col29");
    run(1'b0, 479, 2, 0, 1'b0, "blk479");
    run(1'b0, 0, 1, 0, 1'b0, "blk0");
    run(1'b0, 30719, 2, 0, 1'b0, "oob");
    run(1'b0, 32766, 3, 0, 1'b0, "wrap");
  endtask
  task automatic test_stall();
    run(1'b1, 0, 5, 1, 1'b1, "stall");
  endtask
  task automatic test_count_zero();
    run(1'b0, 123, 0, 0, 1'b0, "cnt0");
  endtask
  task automatic test_reset_mid();
    int seen, n;
    @(negedge clk);
    mode = 1'b1; start_addr = '0; count = 16'd5; start = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; n = 0;
    while (seen < 2 && n < 60) begin
      if (bus.out_valid === 1'b1) seen++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (seen != 2) begin errors++; $display("FAIL rst_mid beats got=%0d want=2", seen); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, bus.out_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid state got=%b want=000", {busy, done, bus.out_valid}); end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL rst_mid done got=%b want=0", done); end
    end
    run(1'b1, 0, 5, 0, 1'b0, "after_rst");
  endtask
  task automatic test_random();
    int a, c;
    bit md;
    for (int t = 0; t < 12; t++) begin
      md = 1'($urandom_range(0, 1));
      a = t % 3 == 0 ? 32768 - int'($urandom_range(1, 4)) : int'($urandom_range(0, 32767));
      c = int'($urandom_range(0, 6));
      run(md, a, c, 2, 1'b0, "rand");
    end
  endtask
  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_count_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
